// File: rtl/russian_peasant_seq_multiplier_ctrl.sv
// Sequential shift-and-add (Russian peasant) unsigned multiplier.
// One doubling/halving iteration per clock, valid/ready on input and output.
// Optional feature macro: RUSSIAN_PEASANT_EARLY_EXIT_EN
//   undefined: always WIDTH RUN cycles (data-independent timing)
//   defined:   RUN also ends once the remaining multiplier bits are all zero
module russian_peasant_seq_multiplier_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned CNT_W  = $clog2(WIDTH) + 1;
  localparam int unsigned PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [PROD_W-1:0]   a_reg;
  logic [WIDTH-1:0]    b_reg;
  logic [PROD_W-1:0]   acc;
  logic [CNT_W-1:0]    count;

  logic [PROD_W-1:0]   acc_sum;
  logic [WIDTH-1:0]    b_shift;
  logic                run_last;

  // Datapath for one iteration: conditional add of the doubled multiplicand.
  assign acc_sum = acc + (b_reg[0] ? a_reg : {PROD_W{1'b0}});
  assign b_shift = b_reg >> 1;

`ifdef RUSSIAN_PEASANT_EARLY_EXIT_EN
  // Stop after the final iteration or once no multiplier bits remain.
  assign run_last = (count == CNT_W'(WIDTH - 1)) || (b_shift == {WIDTH{1'b0}});
`else
  // Stop after exactly WIDTH iterations.
  assign run_last = (count == CNT_W'(WIDTH - 1));
`endif

  // Controller FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= {{WIDTH{1'b0}}, A};
            b_reg    <= B;
            acc      <= '0;
            count    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_sum;
          a_reg <= a_reg << 1;
          b_reg <= b_shift;
          count <= count + CNT_W'(1);
          if (run_last) begin
            product   <= acc_sum;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_russian_peasant_seq_multiplier_ctrl.sv
// Directed bench for russian_peasant_seq_multiplier_ctrl (WIDTH=8).
// Expected RUN-cycle counts follow RUSSIAN_PEASANT_EARLY_EXIT_EN when defined.
module tb_russian_peasant_seq_multiplier_ctrl;

  localparam int unsigned WIDTH = 8;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  logic [2*WIDTH-1:0] results[$];

  russian_peasant_seq_multiplier_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted operand pairs and record delivered products.
  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) accepts <= accepts + 1;
    if (!rst && out_valid && out_ready) results.push_back(product);
  end

  // Expected number of RUN cycles for multiplier b.
  function automatic int exp_runs(input logic [WIDTH-1:0] b);
`ifdef RUSSIAN_PEASANT_EARLY_EXIT_EN
    int r;
    r = 1;
    for (int i = 0; i < int'(WIDTH); i++) if (b[i]) r = i + 1;
    return r;
`else
    return int'(WIDTH);
`endif
  endfunction

  // Run one operation with out_ready=1; returns product, edges from accept to out_valid, and handshake sanity.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output logic [2*WIDTH-1:0] prod, output int lat, output bit flags_ok);
    int guard;
    flags_ok = 1'b1;
    @(negedge clk);
    A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = ~a; B = ~b;
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) flags_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    prod = product;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (product !== 16'd0) begin errors++; $display("FAIL reset_product got %0d exp 0", product); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_basic();
    logic [2*WIDTH-1:0] p; int lat; bit ok;
    run_op(8'd98, 8'd115, p, lat, ok);
    checks++; if (p !== 16'd11270) begin errors++; $display("FAIL basic_product got %0d exp 11270", p); end
    checks++; if (lat !== exp_runs(8'd115) + 1) begin errors++; $display("FAIL basic_latency got %0d exp %0d", lat, exp_runs(8'd115) + 1); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_in_ready_busy got %b exp 1", ok); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0]   av[4] = '{8'd170, 8'd229, 8'd2, 8'd197};
    logic [WIDTH-1:0]   bv[4] = '{8'd99, 8'd42, 8'd186, 8'd2};
    logic [2*WIDTH-1:0] ev[4] = '{16'd16830, 16'd9618, 16'd372, 16'd394};
    int start_acc; int guard;
    @(negedge clk);
    results.delete();
    start_acc = accepts;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      A = av[i]; B = bv[i]; in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (results.size() < 4 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++; if (results.size() !== 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", results.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= results.size()) begin errors++; $display("FAIL b2b_product[%0d] got none exp %0d", i, ev[i]); end
      else if (results[i] !== ev[i]) begin errors++; $display("FAIL b2b_product[%0d] got %0d exp %0d", i, results[i], ev[i]); end
    end
    checks++; if (accepts - start_acc !== 4) begin errors++; $display("FAIL b2b_accepts got %0d exp 4", accepts - start_acc); end
  endtask

  task automatic test_boundaries();
    logic [2*WIDTH-1:0] p; int lat; bit ok;
    run_op(8'd255, 8'd255, p, lat, ok);
    checks++; if (p !== 16'd65025) begin errors++; $display("FAIL ones_product got %0d exp 65025", p); end
    run_op(8'd0, 8'd200, p, lat, ok);
    checks++; if (p !== 16'd0) begin errors++; $display("FAIL a_zero_product got %0d exp 0", p); end
    checks++; if (lat !== exp_runs(8'd200) + 1) begin errors++; $display("FAIL a_zero_latency got %0d exp %0d", lat, exp_runs(8'd200) + 1); end
    run_op(8'd165, 8'd0, p, lat, ok);
    checks++; if (p !== 16'd0) begin errors++; $display("FAIL b_zero_product got %0d exp 0", p); end
    checks++; if (lat !== exp_runs(8'd0) + 1) begin errors++; $display("FAIL b_zero_latency got %0d exp %0d", lat, exp_runs(8'd0) + 1); end
  endtask

  task automatic test_backpressure();
    int guard; int bad;
    @(negedge clk);
    A = 8'd2; B = 8'd42; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid_rise got %b exp 1", out_valid); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || product !== 16'd84 || in_ready !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles exp 0 (product %0d)", bad, product); end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b exp 1", in_ready); end
    checks++; if (product !== 16'd84) begin errors++; $display("FAIL bp_product_kept got %0d exp 84", product); end
  endtask

  task automatic test_reset_mid();
    logic [2*WIDTH-1:0] p; int lat; bit ok; int pulses;
    @(negedge clk);
    A = 8'd98; B = 8'd115; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready got %b exp 1", in_ready); end
    checks++; if (product !== 16'd0) begin errors++; $display("FAIL mid_rst_product got %0d exp 0", product); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL mid_rst_no_out_valid got %0d pulses exp 0", pulses); end
    run_op(8'd3, 8'd5, p, lat, ok);
    checks++; if (p !== 16'd15) begin errors++; $display("FAIL mid_rst_next_product got %0d exp 15", p); end
  endtask

  task automatic test_early_exit();
    logic [WIDTH-1:0]   av[4] = '{8'd197, 8'd2, 8'd7, 8'd1};
    logic [WIDTH-1:0]   bv[4] = '{8'd2, 8'd42, 8'd0, 8'd128};
    logic [2*WIDTH-1:0] ev[4] = '{16'd394, 16'd84, 16'd0, 16'd128};
    logic [2*WIDTH-1:0] p; int lat; bit ok;
    for (int i = 0; i < 4; i++) begin
      run_op(av[i], bv[i], p, lat, ok);
      checks++; if (p !== ev[i]) begin errors++; $display("FAIL ee_product[%0d] got %0d exp %0d", i, p, ev[i]); end
      checks++; if (lat !== exp_runs(bv[i]) + 1) begin errors++; $display("FAIL ee_latency[%0d] got %0d exp %0d", i, lat, exp_runs(bv[i]) + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_boundaries();
    test_backpressure();
    test_reset_mid();
    test_early_exit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
